// File: rtl/vs_mem_pkg.sv
// Shared types and constants for the RAM stream reader.
package vs_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        FINISH = 2'd2
    } vs_rd_state_t;

    // Words that may be outstanding between the RAM and the consumer.
    localparam int unsigned RD_BUF_DEPTH = 2;
    // Width of the buffer occupancy count (0..RD_BUF_DEPTH).
    localparam int unsigned RD_CNT_W     = $clog2(RD_BUF_DEPTH + 1);
    // One extra bit so occupancy + inflight never wraps.
    localparam int unsigned RD_OCC_W     = RD_CNT_W + 1;

endpackage

// File: rtl/vs_ram_stream_reader_if.sv
// Control, RAM-side and stream-side signals of the RAM stream reader.
interface vs_ram_stream_reader_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 16
);

    logic                  start;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH:0]   length;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_ready;

    // Reader side.
    modport master (
        input  start, start_addr, length, ram_rdata, out_ready,
        output busy, done, ram_addr, out_data, out_valid, out_last
    );

    // Requester / RAM / consumer side.
    modport slave (
        output start, start_addr, length, ram_rdata, out_ready,
        input  busy, done, ram_addr, out_data, out_valid, out_last
    );

endinterface

// File: rtl/vs_skid_fifo.sv
// Two-entry FIFO holding {last, data} words between the RAM and the stream port.
module vs_skid_fifo
    import vs_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic                  push_last,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [RD_CNT_W-1:0]   count,
    output logic                  head_valid,
    output logic                  head_last,
    output logic [DATA_WIDTH-1:0] head_data
);

    localparam int unsigned WORD_W = DATA_WIDTH + 1;

    logic [WORD_W-1:0]   head_q, head_d;
    logic [WORD_W-1:0]   tail_q, tail_d;
    logic                head_vld_q, head_vld_d;
    logic                tail_vld_q, tail_vld_d;
    logic [RD_CNT_W-1:0] count_q, count_d;
    logic [WORD_W-1:0]   push_word;
    logic                pop_ok;

    assign push_word = {push_last, push_data};
    assign pop_ok    = pop && head_vld_q;

    // Next-state: pop shifts tail into head; push fills the first free slot.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        head_vld_d = head_vld_q;
        tail_vld_d = tail_vld_q;
        if (pop_ok) begin
            if (tail_vld_q) begin
                head_d = tail_q;
                if (push) begin
                    tail_d = push_word;
                end else begin
                    tail_vld_d = 1'b0;
                end
            end else if (push) begin
                head_d = push_word;
            end else begin
                head_vld_d = 1'b0;
            end
        end else if (push) begin
            if (!head_vld_q) begin
                head_d     = push_word;
                head_vld_d = 1'b1;
            end else if (!tail_vld_q) begin
                tail_d     = push_word;
                tail_vld_d = 1'b1;
            end
        end
        count_d = RD_CNT_W'(head_vld_d) + RD_CNT_W'(tail_vld_d);
    end

    // Storage and occupancy registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
            count_q    <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
            count_q    <= count_d;
        end
    end

    assign count      = count_q;
    assign head_valid = head_vld_q;
    assign head_last  = head_q[WORD_W-1];
    assign head_data  = head_q[DATA_WIDTH-1:0];

endmodule

// File: rtl/vs_ram_stream_reader.sv
// Reads LENGTH contiguous RAM words from START_ADDR and emits them as a valid/ready stream.
module vs_ram_stream_reader
    import vs_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    vs_ram_stream_reader_if.master bus
);

    localparam int unsigned LEN_W = ADDR_WIDTH + 1;

    vs_rd_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]      remaining_q, remaining_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [RD_CNT_W-1:0]   fifo_count;
    logic                  fifo_valid;
    logic                  fifo_last;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  pop_c;
    logic [RD_OCC_W-1:0]   occ_c;
    logic                  issue_c;

    // Words owed to the consumer after this cycle's pop (buffered + in the RAM pipe).
    always_comb begin
        pop_c   = fifo_valid && bus.out_ready;
        occ_c   = RD_OCC_W'(fifo_count) + RD_OCC_W'(inflight_q) - RD_OCC_W'(pop_c);
        issue_c = (state_q == READ) && (remaining_q != '0)
                  && (occ_c < RD_OCC_W'(RD_BUF_DEPTH));
    end

    // Next-state and counter updates.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        remaining_d     = remaining_q;
        inflight_d      = issue_c;
        inflight_last_d = issue_c && (remaining_q == LEN_W'(1));
        busy_d          = busy_q;
        done_d          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.length != '0) begin
                        addr_d      = bus.start_addr;
                        remaining_d = bus.length;
                        busy_d      = 1'b1;
                        state_d     = READ;
                    end else begin
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end
                end
            end
            READ: begin
                if (issue_c) begin
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - LEN_W'(1);
                end
                if ((remaining_q == '0) && (occ_c == '0)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, address/count, pipe-tag and status registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    vs_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (inflight_q),
        .push_last  (inflight_last_q),
        .push_data  (bus.ram_rdata),
        .pop        (pop_c),
        .count      (fifo_count),
        .head_valid (fifo_valid),
        .head_last  (fifo_last),
        .head_data  (fifo_data)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ram_addr  = addr_q;
    assign bus.out_valid = fifo_valid;
    assign bus.out_last  = fifo_last;
    assign bus.out_data  = fifo_data;

endmodule

// File: tb/tb_vs_ram_stream_reader.sv
// Bench for vs_ram_stream_reader: RAM model with mem[a]=a[7:0]^8'h5A, stream scoreboard.
module tb_vs_ram_stream_reader;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    vs_ram_stream_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) if16 ();
    vs_ram_stream_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4))  if4  ();

    vs_ram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) dut16 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (if16)
    );

    vs_ram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut4 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (if4)
    );

    logic        sel4         = 1'b0;
    logic        start_r      = 1'b0;
    logic        out_ready_r  = 1'b0;
    logic [15:0] start_addr_r = '0;
    logic [16:0] length_r     = '0;

    assign if16.start      = start_r & ~sel4;
    assign if4.start       = start_r & sel4;
    assign if16.start_addr = start_addr_r;
    assign if4.start_addr  = start_addr_r[3:0];
    assign if16.length     = length_r;
    assign if4.length      = length_r[4:0];
    assign if16.out_ready  = out_ready_r & ~sel4;
    assign if4.out_ready   = out_ready_r & sel4;

    // Single-port RAM models: registered address, one-cycle read latency.
    logic [15:0] ram16_a = '0;
    logic [3:0]  ram4_a  = '0;
    always @(posedge clock) begin
        ram16_a <= if16.ram_addr;
        ram4_a  <= if4.ram_addr;
    end
    assign if16.ram_rdata = ram16_a[7:0] ^ 8'h5A;
    assign if4.ram_rdata  = {4'h0, ram4_a} ^ 8'h5A;

    logic        obs_valid, obs_last, obs_busy, obs_done;
    logic [7:0]  obs_data;
    logic [15:0] obs_addr;
    always_comb begin
        if (sel4) begin
            obs_valid = if4.out_valid;
            obs_last  = if4.out_last;
            obs_busy  = if4.busy;
            obs_done  = if4.done;
            obs_data  = if4.out_data;
            obs_addr  = {12'h000, if4.ram_addr};
        end else begin
            obs_valid = if16.out_valid;
            obs_last  = if16.out_last;
            obs_busy  = if16.busy;
            obs_done  = if16.done;
            obs_data  = if16.out_data;
            obs_addr  = if16.ram_addr;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"},  32'(obs_busy),  32'd0);
        check_eq({tag, "_done"},  32'(obs_done),  32'd0);
        check_eq({tag, "_valid"}, 32'(obs_valid), 32'd0);
        check_eq({tag, "_last"},  32'(obs_last),  32'd0);
        check_eq({tag, "_data"},  32'(obs_data),  32'd0);
        check_eq({tag, "_addr"},  32'(obs_addr),  32'd0);
    endtask

    // One block read; rmode 0=ready high, 1=pattern 1,0,0, 2=random.
    task automatic run_block(input bit use4, input logic [15:0] sa, input int len,
                             input int rmode, input int mid_at, input bit start_in_finish);
        logic [7:0] exp_d[$];
        bit         exp_l[$];
        int         span, got, last_hs, done_cyc, done_cnt, first_valid, max_lead, budget, lead;
        bit         held, held_last, rdy;
        logic [7:0] held_data;
        span = use4 ? 16 : 65536;
        for (int i = 0; i < len; i++) begin
            int a;
            a = (int'(sa) + i) % span;
            exp_d.push_back(8'(a) ^ 8'h5A);
            exp_l.push_back(i == len - 1);
        end
        got = 0; last_hs = -1; done_cyc = -1; done_cnt = 0; first_valid = -1; max_lead = 0;
        held = 1'b0; held_last = 1'b0; held_data = '0; lead = 0;
        budget = 4 * len + 40;
        @(negedge clock);
        sel4         = use4;
        start_addr_r = sa;
        length_r     = 17'(len);
        out_ready_r  = 1'b0;
        start_r      = 1'b1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clock);
            start_r = 1'b0;
            if (obs_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc == 1) check_eq("busy_after_start", 32'(obs_busy), 32'(len != 0));
            if (held) begin
                check_eq("hold_valid", 32'(obs_valid), 32'd1);
                check_eq("hold_data",  32'(obs_data),  32'(held_data));
                check_eq("hold_last",  32'(obs_last),  32'(held_last));
            end
            if (obs_valid && first_valid < 0) first_valid = cyc;
            if (obs_busy) begin
                lead = ((int'(obs_addr) - int'(sa)) % span + span) % span - got;
                if (lead > max_lead) max_lead = lead;
            end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 3) == 1);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready_r = rdy;
            if (obs_valid && rdy) begin
                if (exp_d.size() == 0) begin
                    check_eq("extra_word", 32'(got + 1), 32'(len));
                end else begin
                    check_eq("data", 32'(obs_data), 32'(exp_d.pop_front()));
                    check_eq("last", 32'(obs_last), 32'(exp_l.pop_front()));
                end
                if (rmode == 0) check_eq("beat_cycle", 32'(cyc), 32'(3 + got));
                got++;
                last_hs = cyc;
            end
            held      = obs_valid && !rdy;
            held_data = obs_data;
            held_last = obs_last;
            if (done_cyc > 0 && cyc > done_cyc) begin
                check_eq("idle_valid", 32'(obs_valid), 32'd0);
                check_eq("idle_busy",  32'(obs_busy),  32'd0);
            end
            if (cyc == mid_at) begin
                start_r      = 1'b1;
                start_addr_r = sa ^ 16'h0055;
                length_r     = 17'd3;
            end
            if (start_in_finish && cyc == done_cyc) start_r = 1'b1;
            if (done_cyc > 0 && cyc >= done_cyc + 3) break;
        end
        start_r     = 1'b0;
        out_ready_r = 1'b0;
        check_eq("word_count", 32'(got), 32'(len));
        check_eq("done_count", 32'(done_cnt), 32'd1);
        check_eq("done_cycle", 32'(done_cyc), (len == 0) ? 32'd1 : 32'(last_hs + 1));
        check_eq("lead_over_2", 32'(max_lead > 2), 32'd0);
        if (rmode == 0 && len != 0) check_eq("first_valid", 32'(first_valid), 32'd3);
        if (len == 0) check_eq("no_valid", 32'(first_valid), 32'hFFFF_FFFF);
    endtask

    // Length-8 read interrupted by reset right after the second handshake.
    task automatic run_reset_mid(input logic [15:0] sa);
        int got;
        got = 0;
        @(negedge clock);
        sel4         = 1'b0;
        start_addr_r = sa;
        length_r     = 17'd8;
        out_ready_r  = 1'b1;
        start_r      = 1'b1;
        for (int cyc = 1; cyc <= 40 && got < 2; cyc++) begin
            @(negedge clock);
            start_r = 1'b0;
            if (obs_valid) got++;
        end
        check_eq("pre_reset_hs", 32'(got), 32'd2);
        @(negedge clock);
        check_eq("pre_reset_busy", 32'(obs_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_eq("rst_done",  32'(obs_done),  32'd0);
            check_eq("rst_valid", 32'(obs_valid), 32'd0);
        end
        out_ready_r = 1'b0;
        reset_n     = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_eq("post_rst_done", 32'(obs_done), 32'd0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        sel4 = 1'b0;
        #1 check_all_zero("reset16");
        sel4 = 1'b1;
        #1 check_all_zero("reset4");
        sel4 = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

        run_block(1'b0, 16'h0010, 4, 0, 0, 1'b0);
        run_block(1'b0, 16'h0010, 4, 1, 0, 1'b0);
        run_block(1'b0, 16'h1234, 0, 0, 0, 1'b0);
        run_block(1'b1, 16'h000E, 4, 0, 0, 1'b0);
        run_block(1'b1, 16'h0005, 16, 2, 0, 1'b0);
        run_block(1'b0, 16'hFFFE, 5, 2, 0, 1'b0);
        run_block(1'b0, 16'h0100, 8, 0, 4, 1'b1);
        run_reset_mid(16'h0200);
        run_block(1'b0, 16'h0200, 8, 0, 0, 1'b0);

        for (int it = 0; it < 14; it++) begin
            bit          u4;
            logic [15:0] sa;
            int          len;
            u4  = 1'($urandom_range(0, 1));
            sa  = u4 ? 16'($urandom_range(0, 15)) : 16'($urandom);
            len = $urandom_range(0, u4 ? 16 : 20);
            run_block(u4, sa, len, $urandom_range(0, 2), 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
